// File: rtl/char_buf_pkg.sv
// Shared types and ASCII control codes for the 16x16 character-buffer writer.
// Constants only; no latency or backpressure.
package char_buf_pkg;

    localparam logic [7:0] ASCII_BS     = 8'h08;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_FF     = 8'h0C;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_SP_MIN = 8'h20;
    localparam logic [7:0] ASCII_PR_MAX = 8'h7E;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    // Row in the upper nibble so the struct maps 1:1 onto char_xy / cursor_xy.
    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } cursor_t;

endpackage

// File: rtl/char_ram_16x16.sv
// 256x7 character store: one synchronous write port, one asynchronous read port.
// Reads are combinational and see a write from the cycle after its edge.
module char_ram_16x16 (
    input  logic       clk,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [6:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [6:0] rdata_o
);

    logic [6:0] mem [256];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/char_buf_writer.sv
// Decodes an ASCII byte stream into cursor moves and writes on a 16x16 text buffer.
// One byte per cycle in IDLE; in_ready is held low for the 256-cycle clear sweep.
module char_buf_writer
    import char_buf_pkg::*;
#(
    parameter logic [6:0] BLANK_CODE     = 7'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    output logic [7:0] cursor_xy,
    output logic       busy
);

    state_t     state_q;
    cursor_t    cursor_q, cursor_d;
    logic [7:0] clr_addr_q;
    logic       in_ready_q;
    logic       busy_q;

    logic       accept;
    logic       go_clear;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [6:0] wr_data;

    assign accept = in_valid & in_ready_q & (state_q == IDLE);

    always_comb begin
        cursor_d = cursor_q;
        go_clear = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = cursor_q;
        wr_data  = in_data[6:0];
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_q;
            wr_data = BLANK_CODE;
        end else if (accept) begin
            if (in_data >= ASCII_SP_MIN && in_data <= ASCII_PR_MAX) begin
                // Treating {row,col} as one 8-bit index gives the line wrap and (15,15)->(0,0) for free.
                wr_en    = 1'b1;
                cursor_d = cursor_t'(cursor_q + 8'd1);
            end else begin
                case (in_data)
                    ASCII_LF: begin
                        cursor_d.col = 4'd0;
                        cursor_d.row = cursor_q.row + 4'd1;
                    end
                    ASCII_CR: cursor_d.col = 4'd0;
                    ASCII_BS: begin
                        cursor_d = (cursor_q == 8'h00) ? cursor_t'(8'h00)
                                                       : cursor_t'(cursor_q - 8'd1);
                        wr_en    = 1'b1;
                        wr_addr  = cursor_d;
                        wr_data  = BLANK_CODE;
                    end
                    ASCII_FF: begin
                        cursor_d = cursor_t'(8'h00);
                        go_clear = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cursor_q   <= cursor_t'(8'h00);
            clr_addr_q <= 8'h00;
            in_ready_q <= 1'b0;
            busy_q     <= CLEAR_ON_RESET;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + 8'd1;
                    if (clr_addr_q == 8'hFF) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    cursor_q   <= cursor_d;
                    in_ready_q <= 1'b1;
                    if (go_clear) begin
                        state_q    <= CLEAR;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    char_ram_16x16 u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (char_xy),
        .rdata_o (char_code)
    );

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign cursor_xy = cursor_q;

endmodule

// File: tb/tb_char_buf_writer.sv
// Directed bench for char_buf_writer: stimulus is driven and sampled on the falling clock edge.
module tb_char_buf_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] char_xy;
    logic [6:0] char_code;
    logic [7:0] cursor_xy;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    char_buf_writer #(.BLANK_CODE(7'h20), .CLEAR_ON_RESET(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .char_xy   (char_xy),
        .char_code (char_code),
        .cursor_xy (cursor_xy),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present one byte for exactly one rising edge; returns on the following falling edge.
    task automatic put(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic count_busy(output int n, output int rdy_hi);
        n = 0;
        rdy_hi = 0;
        while (busy === 1'b1 && n < 400) begin
            if (in_ready !== 1'b0) rdy_hi++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic scan_blank(output int nbad);
        nbad = 0;
        for (int a = 0; a < 256; a++) begin
            char_xy = 8'(a);
            #1;
            if (char_code !== 7'h20) nbad++;
        end
        @(negedge clk);
    endtask

    task automatic peek(input logic [7:0] a, output logic [6:0] v);
        char_xy = a;
        #1;
        v = char_code;
    endtask

    task automatic test_reset;
        int n, r, nbad;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; char_xy = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b want 1", busy); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        checks++; if (cursor_xy !== 8'h00) begin fails++; $display("FAIL rst_cursor: got %h want 00", cursor_xy); end
        rst = 1'b1;
        count_busy(n, r);
        checks++; if (n !== 256) begin fails++; $display("FAIL rst_sweep_len: got %0d want 256", n); end
        checks++; if (r !== 0) begin fails++; $display("FAIL rst_sweep_ready: got %0d ready cycles want 0", r); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_idle_ready: got %b want 1", in_ready); end
        checks++; if (cursor_xy !== 8'h00) begin fails++; $display("FAIL rst_idle_cursor: got %h want 00", cursor_xy); end
        scan_blank(nbad);
        checks++; if (nbad !== 0) begin fails++; $display("FAIL rst_blank: got %0d non-blank want 0", nbad); end
    endtask

    task automatic test_back_to_back;
        logic [6:0] v;
        in_valid = 1'b1; in_data = 8'h41;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        checks++; if (cursor_xy !== 8'h01) begin fails++; $display("FAIL b2b_cursor1: got %h want 01", cursor_xy); end
        in_data = 8'h42;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (cursor_xy !== 8'h02) begin fails++; $display("FAIL b2b_cursor2: got %h want 02", cursor_xy); end
        peek(8'h00, v);
        checks++; if (v !== 7'h41) begin fails++; $display("FAIL b2b_mem0: got %h want 41", v); end
        peek(8'h01, v);
        checks++; if (v !== 7'h42) begin fails++; $display("FAIL b2b_mem1: got %h want 42", v); end
        @(negedge clk);
        put(8'h0A);
        checks++; if (cursor_xy !== 8'h10) begin fails++; $display("FAIL lf_cursor: got %h want 10", cursor_xy); end
    endtask

    task automatic test_form_feed;
        int n, r, nbad;
        put(8'h0C);
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ff_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL ff_busy: got %b want 1", busy); end
        count_busy(n, r);
        checks++; if (n !== 256) begin fails++; $display("FAIL ff_sweep_len: got %0d want 256", n); end
        checks++; if (r !== 0) begin fails++; $display("FAIL ff_sweep_ready: got %0d ready cycles want 0", r); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ff_idle_ready: got %b want 1", in_ready); end
        checks++; if (cursor_xy !== 8'h00) begin fails++; $display("FAIL ff_cursor: got %h want 00", cursor_xy); end
        scan_blank(nbad);
        checks++; if (nbad !== 0) begin fails++; $display("FAIL ff_blank: got %0d non-blank want 0", nbad); end
    endtask

    task automatic test_wrap;
        logic [6:0] v;
        for (int i = 0; i < 16; i++) put(8'(8'h30 + i));
        checks++; if (cursor_xy !== 8'h10) begin fails++; $display("FAIL wrap_row0: got %h want 10", cursor_xy); end
        put(8'h5A);
        checks++; if (cursor_xy !== 8'h11) begin fails++; $display("FAIL wrap_cursor: got %h want 11", cursor_xy); end
        peek(8'h0F, v);
        checks++; if (v !== 7'h3F) begin fails++; $display("FAIL wrap_mem0f: got %h want 3f", v); end
        peek(8'h10, v);
        checks++; if (v !== 7'h5A) begin fails++; $display("FAIL wrap_mem10: got %h want 5a", v); end
        @(negedge clk);
    endtask

    task automatic test_backspace_row;
        logic [6:0] v;
        for (int i = 0; i < 14; i++) put(8'(8'h61 + i));
        checks++; if (cursor_xy !== 8'h1F) begin fails++; $display("FAIL bs_pre_cursor: got %h want 1f", cursor_xy); end
        put(8'h71);
        peek(8'h1F, v);
        checks++; if (v !== 7'h71) begin fails++; $display("FAIL bs_pre_mem: got %h want 71", v); end
        @(negedge clk);
        checks++; if (cursor_xy !== 8'h20) begin fails++; $display("FAIL bs_start: got %h want 20", cursor_xy); end
        put(8'h08);
        checks++; if (cursor_xy !== 8'h1F) begin fails++; $display("FAIL bs_row_cursor: got %h want 1f", cursor_xy); end
        peek(8'h1F, v);
        checks++; if (v !== 7'h20) begin fails++; $display("FAIL bs_row_mem: got %h want 20", v); end
        @(negedge clk);
    endtask

    task automatic test_carriage_return;
        logic [6:0] v;
        put(8'h0A);
        put(8'h0A);
        for (int i = 0; i < 5; i++) put(8'(8'h41 + i));
        checks++; if (cursor_xy !== 8'h35) begin fails++; $display("FAIL cr_pre: got %h want 35", cursor_xy); end
        put(8'h0D);
        checks++; if (cursor_xy !== 8'h30) begin fails++; $display("FAIL cr_cursor: got %h want 30", cursor_xy); end
        peek(8'h34, v);
        checks++; if (v !== 7'h45) begin fails++; $display("FAIL cr_mem: got %h want 45", v); end
        @(negedge clk);
    endtask

    task automatic test_ignored;
        logic [6:0] v;
        put(8'h80);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ign_ready: got %b want 1", in_ready); end
        put(8'h01);
        checks++; if (cursor_xy !== 8'h30) begin fails++; $display("FAIL ign_cursor: got %h want 30", cursor_xy); end
        peek(8'h30, v);
        checks++; if (v !== 7'h41) begin fails++; $display("FAIL ign_mem: got %h want 41", v); end
        @(negedge clk);
    endtask

    task automatic test_bs_origin;
        logic [6:0] v;
        for (int i = 0; i < 13; i++) put(8'h0A);
        checks++; if (cursor_xy !== 8'h00) begin fails++; $display("FAIL lf_rowwrap: got %h want 00", cursor_xy); end
        peek(8'h00, v);
        checks++; if (v !== 7'h30) begin fails++; $display("FAIL bs0_pre_mem: got %h want 30", v); end
        @(negedge clk);
        put(8'h08);
        checks++; if (cursor_xy !== 8'h00) begin fails++; $display("FAIL bs0_cursor: got %h want 00", cursor_xy); end
        peek(8'h00, v);
        checks++; if (v !== 7'h20) begin fails++; $display("FAIL bs0_mem: got %h want 20", v); end
        @(negedge clk);
    endtask

    task automatic test_corner_wrap;
        logic [6:0] v;
        for (int i = 0; i < 15; i++) put(8'h0A);
        for (int i = 0; i < 15; i++) put(8'h61);
        checks++; if (cursor_xy !== 8'hFF) begin fails++; $display("FAIL corner_pre: got %h want ff", cursor_xy); end
        put(8'h58);
        checks++; if (cursor_xy !== 8'h00) begin fails++; $display("FAIL corner_cursor: got %h want 00", cursor_xy); end
        peek(8'hFF, v);
        checks++; if (v !== 7'h58) begin fails++; $display("FAIL corner_mem: got %h want 58", v); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stream;
        int n, r;
        put(8'h4D);
        checks++; if (cursor_xy !== 8'h01) begin fails++; $display("FAIL rms_pre: got %h want 01", cursor_xy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (cursor_xy !== 8'h00) begin fails++; $display("FAIL rms_cursor: got %h want 00", cursor_xy); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rms_busy: got %b want 1", busy); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rms_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        count_busy(n, r);
        checks++; if (n !== 256) begin fails++; $display("FAIL rms_sweep_len: got %0d want 256", n); end
        checks++; if (r !== 0) begin fails++; $display("FAIL rms_sweep_ready: got %0d ready cycles want 0", r); end
    endtask

    task automatic test_reset_mid_sweep;
        int n, r, nbad;
        put(8'h41);
        put(8'h0C);
        repeat (100) @(negedge clk);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rsw_mid_busy: got %b want 1", busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rsw_ready: got %b want 0", in_ready); end
        checks++; if (cursor_xy !== 8'h00) begin fails++; $display("FAIL rsw_cursor: got %h want 00", cursor_xy); end
        @(negedge clk);
        rst = 1'b1;
        count_busy(n, r);
        checks++; if (n !== 256) begin fails++; $display("FAIL rsw_sweep_len: got %0d want 256", n); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rsw_idle_ready: got %b want 1", in_ready); end
        scan_blank(nbad);
        checks++; if (nbad !== 0) begin fails++; $display("FAIL rsw_blank: got %0d non-blank want 0", nbad); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_form_feed();
        test_wrap();
        test_backspace_row();
        test_carriage_return();
        test_ignored();
        test_bs_origin();
        test_corner_wrap();
        test_reset_mid_stream();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/char_buf_writer.md
Name: char_buf_writer

Overview:
- Writer side of the 16x16 on-screen text path.
- Accepts ASCII bytes over a valid/ready stream (from UART or keyboard logic) and interprets control codes. Printable characters are written at a cursor into a 256-entry character buffer.
- Exposes a combinational char_xy -> char_code lookup port, so it drops in where the 16x16 character ROM feeds the text-overlay draw block. On-screen text becomes runtime-writable.

Parameters:
- BLANK_CODE, 7'h20, code written by clear sweeps and backspace.
- CLEAR_ON_RESET, 1, 1 = run a full clear sweep after reset; 0 = go straight to IDLE, buffer contents undefined.

Ports:
- clk  in  1  system clock (pixel clock domain of the draw pipeline)
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  byte available on in_data
- in_data  in  8  ASCII byte
- in_ready  out  1  block can accept a byte this cycle
- char_xy  in  8  read address, [7:4]=row, [3:0]=col
- char_code  out  7  character code at char_xy (combinational)
- cursor_xy  out  8  current cursor, same format as char_xy
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (rst=0, async):
  - in_ready=0, cursor_xy=8'h00, clear address=0.
  - State=CLEAR if CLEAR_ON_RESET, else IDLE. busy=1 while in CLEAR.
  - Buffer memory itself is not reset.
- States: CLEAR, IDLE.
- CLEAR:
  - Writes BLANK_CODE at clear address each cycle; the address increments 0..255.
  - After writing 255: go to IDLE next cycle, busy=0, in_ready=1.
  - Sweep is exactly 256 cycles. in_ready=0 throughout; in_data ignored.
- IDLE:
  - in_ready=1.
  - Byte accepted on in_valid & in_ready. One byte per cycle sustained, no bubbles.
  - Decode of accepted byte b, with cursor (r,c):
    - 8'h20..8'h7E: write b[6:0] at (r,c). Cursor advances: c<15 -> c+1; c=15 -> c=0, r=r+1 mod 16. (15,15) wraps to (0,0); no scrolling.
    - 8'h0A (LF): c=0, r=r+1 mod 16, no write.
    - 8'h0D (CR): c=0, r unchanged, no write.
    - 8'h08 (BS): new position = c>0 ? (r,c-1) : r>0 ? (r-1,15) : (0,0). BLANK_CODE written at the new position in the same cycle; cursor moves there.
    - 8'h0C (FF): cursor=(0,0), enter CLEAR next cycle. in_ready drops the cycle after acceptance.
    - All other values (including bit7=1): accepted, no write, cursor unchanged.
  - Cursor update and RAM write both take effect at the clock edge of acceptance. cursor_xy reflects the new value the following cycle.
- Read port:
  - char_code = mem[char_xy], combinational, no latency.
  - A write becomes visible on the cycle after the write edge. Read of the address being written in the same cycle returns the old value.
- Single write port, muxed: CLEAR uses the clear address and BLANK_CODE; IDLE uses the cursor and the decoded data. No simultaneous write sources are possible.
- rst asserted mid-sweep or mid-stream: restarts the sweep from address 0 and sets the cursor to 0.

Decomposition:
- Package char_buf_pkg:
  - ASCII constants: ASCII_BS=8'h08, ASCII_LF=8'h0A, ASCII_FF=8'h0C, ASCII_CR=8'h0D, ASCII_SP_MIN=8'h20, ASCII_PR_MAX=8'h7E.
  - State enum typedef state_t {CLEAR, IDLE}.
  - Cursor struct typedef cursor_t {row[3:0], col[3:0]}.
- One sub-module, char_ram_16x16: 256x7, one synchronous write port, one asynchronous read port. Distributed RAM, no reset.
- Top level holds the FSM, cursor logic and decode.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy=1 and in_ready=0 for 256 cycles. Then busy=0 and in_ready=1; every char_xy 0..255 reads 7'h20; cursor_xy=8'h00.
- Stream "AB" back-to-back with in_valid held high -> both bytes accepted on consecutive cycles. char_xy 8'h00 reads 7'h41, 8'h01 reads 7'h42; cursor_xy=8'h02.
- 16 printable bytes from (0,0), then 'Z' -> row-0 wrap puts 'Z' at char_xy 8'h10, cursor 8'h11. Cursor at 8'hFF plus one byte -> written at 8'hFF, cursor 8'h00.
- Control codes:
  - "AB" then LF -> cursor 8'h10.
  - CR from (3,5) -> cursor 8'h30.
  - BS at (2,0) -> cursor 8'h1F, 8'h1F reads 7'h20.
  - BS at (0,0) -> cursor stays 8'h00, 8'h00 reads 7'h20.
  - 8'h80 and 8'h01 -> accepted, no change.
- FF after filled text -> in_ready=0 and busy=1 from the next cycle for 256 cycles. Buffer reads all 7'h20 afterwards; cursor 8'h00.
- Pulse rst low at sweep address ~100, or mid-stream -> outputs immediately return to reset values. A full 256-cycle sweep follows.
